cache_mem_responder: RTL

- Memory-side responder for the 2-way set-associative cache: the backing store the cache fills from and writes dirty victims back to.
- Accepts single-byte read (fill) and write (writeback) requests over a valid/ready handshake.
- Writes are posted into a small write buffer and drained to a single-port array with configurable access latency.
- Reads forward from the write buffer on an address match; otherwise they access the array and return data on a valid/ready response channel.

---
 rtl/cache_mem_pkg.sv | 19 +
 rtl/cache_mem_responder_if.sv | 44 ++++
 rtl/cache_mem_responder_wb_fifo.sv | 82 ++++++++
 rtl/cache_mem_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the cache memory responder.
// Imported by the interface, the write buffer and the top.
package cache_mem_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Request/response bundle between the cache and its backing store.
// master = cache side, slave = memory responder side.
interface cache_mem_responder_if
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              wb_empty;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  wb_empty
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output wb_empty
    );

endinterface

// File: rtl/cache_mem_responder_wb_fifo.sv
// Posted-write FIFO with a combinational youngest-entry address lookup.
// Occupancy is held in a count register so any depth wraps cleanly.
module wb_fifo
    import cache_mem_pkg::*;
#(
    parameter int AW    = ADDR_W_DEF,
    parameter int DW    = DATA_W_DEF,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic [AW-1:0] lookup_addr,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          hit,
    output logic [DW-1:0] hit_data,
    output logic          full,
    output logic          empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end

    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // Walk oldest to youngest so the last match seen is the newest write.
    always_comb begin
        int s;
        hit      = 1'b0;
        hit_data = '0;
        s        = 0;
        for (int k = 0; k < DEPTH; k++) begin
            s = int'(head) + k;
            if (s >= DEPTH) s = s - DEPTH;
            if (k < int'(count) && addr_q[PTR_W'(s)] == lookup_addr) begin
                hit      = 1'b1;
                hit_data = data_q[PTR_W'(s)];
            end
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Backing store for the set-associative cache: posted writes, forwarded
// reads and a fixed-latency single-port array behind a small write buffer.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LATENCY  = 2,
    parameter int WB_DEPTH = 2
) (
    input logic                  clk,
    input logic                  Reset_n,
    cache_mem_responder_if.slave bus
);

    localparam int MEM_N = 2 ** ADDR_W;
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [DATA_W-1:0] mem [MEM_N];

    logic              xfer;
    logic              push;
    logic              pop;
    logic              mem_we;
    logic              cap_fwd;
    logic              cap_arr;
    logic              latch_addr;
    logic              resp_clr;

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              full;
    logic              empty;

    wb_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk         (clk),
        .rst_n       (Reset_n),
        .push        (push),
        .push_addr   (bus.req_addr),
        .push_data   (bus.req_wdata),
        .pop         (pop),
        .lookup_addr (bus.req_addr),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .hit         (hit),
        .hit_data    (hit_data),
        .full        (full),
        .empty       (empty)
    );

    assign bus.req_ready  = Reset_n && (state == IDLE) && !full;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.wb_empty   = empty;
    assign xfer           = bus.req_valid && bus.req_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        push       = 1'b0;
        pop        = 1'b0;
        mem_we     = 1'b0;
        cap_fwd    = 1'b0;
        cap_arr    = 1'b0;
        latch_addr = 1'b0;
        resp_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                // A transfer wins over starting a drain.
                if (xfer && bus.req_write) begin
                    push = 1'b1;
                end else if (xfer && hit) begin
                    cap_fwd    = 1'b1;
                    state_next = RESP;
                end else if (xfer) begin
                    latch_addr = 1'b1;
                    cnt_next   = LAT_M1;
                    state_next = READ;
                end else if (!empty) begin
                    cnt_next   = LAT_M1;
                    state_next = DRAIN;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    cap_arr    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    mem_we     = 1'b1;
                    pop        = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_clr   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_addr    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (latch_addr) rd_addr <= bus.req_addr;
            if (cap_fwd) begin
                resp_valid <= 1'b1;
                resp_rdata <= hit_data;
            end else if (cap_arr) begin
                resp_valid <= 1'b1;
                resp_rdata <= mem[rd_addr];
            end else if (resp_clr) begin
                resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[head_addr] <= head_data;
        end
    end

endmodule
